// File: rtl/reg64_write_arbiter_pkg.sv
// Shared definitions for the 64-bit register write arbiter:
// FSM state encoding plus the beat and word widths.
package reg64_write_arbiter_pkg;

  localparam int BEAT_W = 32;
  localparam int WORD_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LO     = 2'd1,
    ST_HI     = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

endpackage

// File: rtl/reg64_write_arbiter_rr_arbiter.sv
// Purely combinational round-robin selector: the search starts one past
// last_grant and wraps, so the most recent grantee has the lowest priority.
module rr_arbiter
  import reg64_write_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [IDW-1:0]  winner,
  output logic            any_req
);

  // Wrapped indices are scanned first and then overridden by any requester
  // above last_grant, so the nearest index after last_grant wins.
  always_comb begin
    winner  = {IDW{1'b0}};
    any_req = |req;
    for (int i = NREQ - 1; i >= 0; i--) begin
      winner = (req[i] && (IDW'(i) <= last_grant)) ? IDW'(i) : winner;
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      winner = (req[i] && (IDW'(i) > last_grant)) ? IDW'(i) : winner;
    end
  end

endmodule

// File: rtl/reg64_write_arbiter.sv
// Shares one 64-bit register write port among NREQ requesters that each send
// a transfer as a low beat then a high beat; the write is issued atomically.
module reg64_write_arbiter
  import reg64_write_arbiter_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*BEAT_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     reg_write,
  output logic [WORD_W-1:0]        reg_writedata,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic                     err
);

  localparam int IDW = $clog2(NREQ);
  localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW:0] TLIM = (TW + 1)'(TIMEOUT);
  localparam logic [TW:0] TONE = (TW + 1)'(1);

  state_t              state_r, state_s;
  logic [IDW-1:0]      grant_r, grant_s, last_r, last_s, winner_s;
  logic                any_s, hs_s, expire_s, abort_s, lo_en_s, hi_en_s;
  logic [TW-1:0]       timer_r, timer_s;
  logic [TW:0]         tinc_s;
  logic [BEAT_W-1:0]   lo_r, beat_s;
  logic [WORD_W-1:0]   wd_r;
  logic [NREQ-1:0]     ready_r, ready_s;
  logic                write_r, busy_r, err_r;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req        (req_valid),
    .last_grant (last_r),
    .winner     (winner_s),
    .any_req    (any_s)
  );

  // Select the grantee's beat from the flattened data bus.
  always_comb begin
    beat_s = {BEAT_W{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      beat_s = (grant_r == IDW'(i)) ? req_data[i*BEAT_W +: BEAT_W] : beat_s;
    end
  end

  // Ready is registered, so a handshake is just valid meeting the held ready bit.
  assign hs_s     = |(req_valid & ready_r);
  assign tinc_s   = {1'b0, timer_r} + TONE;
  assign expire_s = (TIMEOUT != 0) && (tinc_s == TLIM);

  // Next-state, timer and latch-enable decode.
  always_comb begin
    state_s = state_r;
    grant_s = grant_r;
    last_s  = last_r;
    timer_s = timer_r;
    abort_s = 1'b0;
    lo_en_s = 1'b0;
    hi_en_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        timer_s = {TW{1'b0}};
        if (any_s) begin
          grant_s = winner_s;
          state_s = ST_LO;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LO, ST_HI: begin
        if (hs_s) begin
          timer_s = {TW{1'b0}};
          lo_en_s = (state_r == ST_LO);
          hi_en_s = (state_r == ST_HI);
          state_s = (state_r == ST_LO) ? ST_HI : ST_COMMIT;
        end else if (expire_s) begin
          abort_s = 1'b1;
          last_s  = grant_r;
          timer_s = {TW{1'b0}};
          state_s = ST_IDLE;
        end else begin
          timer_s = tinc_s[TW-1:0];
        end
      end
      ST_COMMIT: begin
        last_s  = grant_r;
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Ready for the cycle after this edge, decoded from next state and grant only.
  always_comb begin
    ready_s = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      ready_s[i] = ((state_s == ST_LO) || (state_s == ST_HI)) && (grant_s == IDW'(i));
    end
  end

  // State, data latches and registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      grant_r <= {IDW{1'b0}};
      last_r  <= IDW'(NREQ - 1);
      timer_r <= {TW{1'b0}};
      lo_r    <= {BEAT_W{1'b0}};
      wd_r    <= {WORD_W{1'b0}};
      ready_r <= {NREQ{1'b0}};
      write_r <= 1'b0;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
      last_r  <= last_s;
      timer_r <= timer_s;
      ready_r <= ready_s;
      write_r <= (state_s == ST_COMMIT);
      busy_r  <= (state_s != ST_IDLE);
      err_r   <= abort_s;
      if (lo_en_s) lo_r <= beat_s;
      if (hi_en_s) wd_r <= {beat_s, lo_r};
    end
  end

  assign req_ready     = ready_r;
  assign reg_write     = write_r;
  assign reg_writedata = wd_r;
  assign grant_id      = grant_r;
  assign busy          = busy_r;
  assign err           = err_r;

endmodule
